// File: rtl/lifo_stack_pkg.sv
// rtl/lifo_stack_pkg.sv - default sizing and word type for the lifo_stack scratch buffer
package lifo_stack_pkg;

    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_DEPTH      = 8;

    typedef logic [DEF_DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - single-clock LIFO stack with registered pop output and full/empty flags
module lifo_stack
    import lifo_stack_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  push,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0]      count;
    logic [AW-1:0]         top_idx;
    logic [AW-1:0]         wr_idx;
    logic                  do_pop;
    logic                  do_push;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A push while full is still taken when it pairs with a valid pop (replace-top).
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign top_idx = AW'(count - CNT_W'(1));
    assign wr_idx  = AW'(count);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count    <= '0;
            data_out <= '0;
        end else begin
            if (do_pop && do_push) begin
                data_out     <= mem[top_idx];
                mem[top_idx] <= data_in;
            end else if (do_pop) begin
                data_out <= mem[top_idx];
                count    <= count - CNT_W'(1);
            end else if (do_push) begin
                mem[wr_idx] <= data_in;
                count       <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lifo_stack.sv
// tb/tb_lifo_stack.sv - self-checking bench for lifo_stack using a reference stack and pop scoreboard
module tb_lifo_stack;

    localparam int DW    = 4;
    localparam int DEPTH = 8;

    logic          clk;
    logic          rstN;
    logic [DW-1:0] data_in;
    logic          push;
    logic          pop;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;

    int n_checks;
    int n_errors;

    logic [DW-1:0] model [$];
    logic [DW-1:0] sb    [$];
    logic [DW-1:0] exp_out;

    lifo_stack #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .data_in  (data_in),
        .push     (push),
        .pop      (pop),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, ".full"},  int'(full),  int'(model.size() == DEPTH));
        check({tag, ".empty"}, int'(empty), int'(model.size() == 0));
    endtask

    // One clock: drive requests, update the reference stack, compare after the edge.
    task automatic step(input logic p, input logic q, input logic [DW-1:0] d, input string tag);
        logic vpop;
        logic vpush;
        push    = p;
        pop     = q;
        data_in = d;
        vpop  = q && (model.size() > 0);
        vpush = p && ((model.size() < DEPTH) || vpop);
        if (vpop)
            sb.push_back(model[model.size()-1]);
        if (vpop && vpush)
            model[model.size()-1] = d;
        else if (vpop)
            void'(model.pop_back());
        else if (vpush)
            model.push_back(d);
        @(posedge clk);
        #1;
        if (vpop && sb.size() > 0)
            exp_out = sb.pop_front();
        check({tag, ".data_out"}, int'(data_out), int'(exp_out));
        check_flags(tag);
        push = 1'b0;
        pop  = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset(input string tag);
        rstN = 1'b0;
        #2;
        model.delete();
        exp_out = '0;
        check({tag, ".data_out"}, int'(data_out), 0);
        check_flags(tag);
        #1;
        rstN = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_out  = '0;
        push     = 1'b0;
        pop      = 1'b0;
        data_in  = '0;
        rstN     = 1'b0;
        #12;
        rstN = 1'b1;
        check("reset.data_out", int'(data_out), 0);
        check("reset.empty", int'(empty), 1);
        check("reset.full", int'(full), 0);

        // Fill with A..E then pop once
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(10 + i), "fill");
        step(1'b0, 1'b1, '0, "pop_e");
        check("pop_e.value", int'(data_out), 14);

        // Replace-top then pop the replacement
        step(1'b1, 1'b1, 4'd4, "replace");
        check("replace.value", int'(data_out), 13);
        step(1'b0, 1'b1, '0, "pop_rep");
        check("pop_rep.value", int'(data_out), 4);

        // Overflow: six pushes from count 3, last one dropped
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, DW'(15 + i), "ovf");
        check("ovf.full", int'(full), 1);
        step(1'b1, 1'b1, 4'd9, "replace_full");
        check("replace_full.full", int'(full), 1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, "ovf_pop");
        check("ovf_pop.full", int'(full), 0);

        // Mid-sequence reset discards data; then underflow
        do_reset("reset2");
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 4'd7, "underflow");

        // Both requested while empty: only the push happens
        step(1'b1, 1'b1, 4'd14, "both_empty");
        check("both_empty.empty", int'(empty), 0);
        step(1'b0, 1'b1, '0, "pop_14");
        check("pop_14.value", int'(data_out), 14);

        // Idle with toggling data_in, then drain through the whole depth
        step(1'b1, 1'b0, 4'd3, "refill");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, DW'($urandom_range(0, 15)), "idle");
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i), "fill2");
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, '0, "drain");

        check("scoreboard.left", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
